cursor_ctrl: RTL and testbench

Keyboard-driven cursor and text-entry controller for the 20×15 cell character display (32×32-pixel cells, 640×480 active area). It sits directly upstream of the pixel generator and drives its `writing_x`, `writing_y` and `editing` inputs. It also issues single-character writes into the character memory that backs the word/font path. Key events come from the keyboard decoder; writes use a valid/ready handshake because the memory port is shared.

---
 rtl/display_pkg.sv | 16 +
 rtl/cursor_ctrl.sv | 144 ++++++++++++++
 tb/tb_cursor_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared geometry, key command codes and cursor FSM states for the character display
package display_pkg;
    localparam int DISP_COLS = 20;
    localparam int DISP_ROWS = 15;
    localparam int CELL_PX   = 32;
    localparam logic [6:0] BLANK_CHAR = 7'h20;
    localparam logic [2:0] CMD_UP    = 3'd0;
    localparam logic [2:0] CMD_DOWN  = 3'd1;
    localparam logic [2:0] CMD_LEFT  = 3'd2;
    localparam logic [2:0] CMD_RIGHT = 3'd3;
    localparam logic [2:0] CMD_ENTER = 3'd4;
    localparam logic [2:0] CMD_BKSP  = 3'd5;
    localparam logic [2:0] CMD_ESC   = 3'd6;
    localparam logic [2:0] CMD_CLEAR = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_WRITE, ST_CLEAR} state_t;
endpackage

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: keyboard-driven cursor movement and single-character writes into character memory
module cursor_ctrl
    import display_pkg::*;
#(
    parameter int COLS = DISP_COLS,
    parameter int ROWS = DISP_ROWS,
    parameter int AW   = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic          key_is_char,
    input  logic [6:0]    key_char,
    input  logic [2:0]    key_cmd,
    output logic [4:0]    writing_x,
    output logic [4:0]    writing_y,
    output logic          editing,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [6:0]    wr_data,
    input  logic          wr_ready
);
    localparam logic [4:0]    X_MAX = 5'(COLS - 1);
    localparam logic [4:0]    Y_MAX = 5'(ROWS - 1);
    localparam logic [AW-1:0] A_MAX = AW'(COLS * ROWS - 1);

    state_t        r_state;
    logic [4:0]    r_x, r_y;
    logic          r_wr_en, r_bksp;
    logic [AW-1:0] r_wr_addr;
    logic [6:0]    r_wr_data;
    logic [9:0]    w_fwd, w_back;
    logic [AW-1:0] w_addr, w_back_addr;
    logic          w_key;

    // Linear cell step: forward walks row-major, backward is its inverse; both wrap the whole screen
    function automatic logic [9:0] step(input logic [4:0] x, input logic [4:0] y, input logic fwd);
        logic [4:0] nx, ny;
        if (fwd) begin
            nx = (x == X_MAX) ? 5'd0 : x + 5'd1;
            ny = (x != X_MAX) ? y : (y == Y_MAX) ? 5'd0 : y + 5'd1;
        end else begin
            nx = (x == 5'd0) ? X_MAX : x - 5'd1;
            ny = (x != 5'd0) ? y : (y == 5'd0) ? Y_MAX : y - 5'd1;
        end
        return {nx, ny};
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] x, input logic [4:0] y);
        return AW'(y) * AW'(COLS) + AW'(x);
    endfunction

    assign w_fwd       = step(r_x, r_y, 1'b1);
    assign w_back      = step(r_x, r_y, 1'b0);
    assign w_addr      = cell_addr(r_x, r_y);
    assign w_back_addr = cell_addr(w_back[9:5], w_back[4:0]);
    assign key_ready   = (r_state == ST_IDLE) || (r_state == ST_EDIT);
    assign w_key       = key_valid && key_ready;
    assign editing     = (r_state == ST_EDIT) || (r_state == ST_WRITE);
    assign writing_x   = r_x;
    assign writing_y   = r_y;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_wr_en   <= 1'b0;
            r_bksp    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_key && !key_is_char) begin
                    if (key_cmd == CMD_ENTER) r_state <= ST_EDIT;
                    if (key_cmd == CMD_CLEAR) begin
                        r_state   <= ST_CLEAR;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= BLANK_CHAR;
                    end
                end
                ST_EDIT: if (w_key) begin
                    if (key_is_char) begin
                        r_state   <= ST_WRITE;
                        r_wr_en   <= 1'b1;
                        r_bksp    <= 1'b0;
                        r_wr_addr <= w_addr;
                        r_wr_data <= key_char;
                    end else begin
                        case (key_cmd)
                            CMD_UP:    r_y <= (r_y == 5'd0) ? Y_MAX : r_y - 5'd1;
                            CMD_DOWN:  r_y <= (r_y == Y_MAX) ? 5'd0 : r_y + 5'd1;
                            CMD_LEFT:  r_x <= (r_x == 5'd0) ? X_MAX : r_x - 5'd1;
                            CMD_RIGHT: r_x <= (r_x == X_MAX) ? 5'd0 : r_x + 5'd1;
                            CMD_ENTER: begin
                                r_x <= 5'd0;
                                r_y <= (r_y == Y_MAX) ? 5'd0 : r_y + 5'd1;
                            end
                            CMD_BKSP: begin
                                r_x       <= w_back[9:5];
                                r_y       <= w_back[4:0];
                                r_state   <= ST_WRITE;
                                r_wr_en   <= 1'b1;
                                r_bksp    <= 1'b1;
                                r_wr_addr <= w_back_addr;
                                r_wr_data <= BLANK_CHAR;
                            end
                            CMD_ESC:   r_state <= ST_IDLE;
                            default: begin
                                r_state   <= ST_CLEAR;
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= '0;
                                r_wr_data <= BLANK_CHAR;
                            end
                        endcase
                    end
                end
                ST_WRITE: if (wr_ready) begin
                    r_wr_en <= 1'b0;
                    r_state <= ST_EDIT;
                    if (!r_bksp) begin
                        r_x <= w_fwd[9:5];
                        r_y <= w_fwd[4:0];
                    end
                end
                default: if (wr_ready) begin
                    if (r_wr_addr == A_MAX) begin
                        r_wr_en <= 1'b0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wr_addr <= r_wr_addr + AW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed self-checking bench for cursor_ctrl
module tb_cursor_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic       key_is_char = 1'b0;
    logic [6:0] key_char = '0;
    logic [2:0] key_cmd = '0;
    logic [4:0] writing_x, writing_y;
    logic       editing, wr_en;
    logic [8:0] wr_addr;
    logic [6:0] wr_data;
    logic       wr_ready = 1'b1;
    int checks = 0;
    int failures = 0;

    localparam logic [2:0] UP = 3'd0, DOWN = 3'd1, LEFT = 3'd2, RIGHT = 3'd3,
                           ENTER = 3'd4, BKSP = 3'd5, ESC = 3'd6, CLR = 3'd7;

    cursor_ctrl #(.COLS(20), .ROWS(15), .AW(9)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_is_char(key_is_char), .key_char(key_char), .key_cmd(key_cmd),
        .writing_x(writing_x), .writing_y(writing_y), .editing(editing),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] c);
        key_valid = 1'b1;
        key_is_char = 1'b0;
        key_cmd = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic chr(input logic [6:0] ch);
        key_valid = 1'b1;
        key_is_char = 1'b1;
        key_char = ch;
        tick();
        key_valid = 1'b0;
        key_is_char = 1'b0;
    endtask

    task automatic cur(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(writing_x), 32'(x));
        chk({tag, "_y"}, 32'(writing_y), 32'(y));
    endtask

    task automatic rst_state(input string tag);
        cur(tag, 0, 0);
        chk({tag, "_editing"}, 32'(editing), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_key_ready"}, 32'(key_ready), 1);
    endtask

    initial begin
        #1;
        tick();
        tick();
        rst = 1'b0;
        rst_state("reset");
        chr(7'h51);
        cur("idle_char", 0, 0);
        chk("idle_char_wr_en", 32'(wr_en), 0);
        cmd(ENTER);
        chk("enter_editing", 32'(editing), 1);
        cur("enter", 0, 0);
        chk("enter_key_ready", 32'(key_ready), 1);
        chk("enter_wr_en", 32'(wr_en), 0);
        // char at end of row 0 wraps to the start of row 1
        cmd(LEFT);
        cur("left_wrap0", 19, 0);
        chr(7'h41);
        chk("a_wr_en", 32'(wr_en), 1);
        chk("a_addr", 32'(wr_addr), 19);
        chk("a_data", 32'(wr_data), 32'h41);
        chk("a_key_ready", 32'(key_ready), 0);
        tick();
        chk("a_wr_en_drop", 32'(wr_en), 0);
        cur("a_adv", 0, 1);
        chk("a_key_ready_back", 32'(key_ready), 1);
        cmd(DOWN);
        for (int i = 0; i < 3; i++) cmd(RIGHT);
        cur("at_3_2", 3, 2);
        // stalled write with a RIGHT key arriving mid-stall
        wr_ready = 1'b0;
        chr(7'h42);
        chk("b_wr_en", 32'(wr_en), 1);
        chk("b_addr", 32'(wr_addr), 43);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                chk("b_key_ready_stall", 32'(key_ready), 0);
                cmd(RIGHT);
            end else tick();
            chk("b_wr_en_hold", 32'(wr_en), 1);
            chk("b_addr_hold", 32'(wr_addr), 43);
            chk("b_data_hold", 32'(wr_data), 32'h42);
            cur("b_stall", 3, 2);
        end
        wr_ready = 1'b1;
        tick();
        chk("b_wr_en_done", 32'(wr_en), 0);
        cur("b_adv", 4, 2);
        cmd(ENTER);
        cur("enter_row", 0, 3);
        cmd(LEFT);
        cur("left_wrap", 19, 3);
        cmd(RIGHT);
        for (int i = 0; i < 3; i++) cmd(UP);
        for (int i = 0; i < 5; i++) cmd(RIGHT);
        cur("at_5_0", 5, 0);
        cmd(UP);
        cur("up_wrap", 5, 14);
        for (int i = 0; i < 5; i++) cmd(LEFT);
        cmd(DOWN);
        cur("down_wrap", 0, 0);
        // backspace at origin wraps to the last cell and stays there
        cmd(BKSP);
        cur("bksp", 19, 14);
        chk("bksp_wr_en", 32'(wr_en), 1);
        chk("bksp_addr", 32'(wr_addr), 299);
        chk("bksp_data", 32'(wr_data), 32'h20);
        tick();
        chk("bksp_wr_en_done", 32'(wr_en), 0);
        cur("bksp_stay", 19, 14);
        chk("bksp_editing", 32'(editing), 1);
        cmd(RIGHT);
        for (int i = 0; i < 7; i++) cmd(RIGHT);
        cur("at_7_14", 7, 14);
        cmd(ENTER);
        cur("enter_wrap", 0, 0);
        cmd(RIGHT);
        cmd(RIGHT);
        cmd(DOWN);
        cmd(ESC);
        chk("esc_editing", 32'(editing), 0);
        cur("esc", 2, 1);
        chk("esc_key_ready", 32'(key_ready), 1);
        // full-screen clear with one write per cycle
        cmd(CLR);
        chk("clr_editing", 32'(editing), 0);
        chk("clr_data", 32'(wr_data), 32'h20);
        chk("clr_key_ready", 32'(key_ready), 0);
        for (int i = 0; i < 300; i++) begin
            chk("clr_wr_en", 32'(wr_en), 1);
            chk("clr_addr", 32'(wr_addr), 32'(i));
            tick();
        end
        chk("clr_done_wr_en", 32'(wr_en), 0);
        cur("clr_done", 0, 0);
        chk("clr_done_key_ready", 32'(key_ready), 1);
        chk("clr_done_editing", 32'(editing), 0);
        cmd(CLR);
        for (int i = 0; i < 120; i++) tick();
        chk("clr2_addr", 32'(wr_addr), 120);
        chk("clr2_wr_en", 32'(wr_en), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rst_state("mid_clear_rst");
        tick();
        chk("post_rst_wr_en", 32'(wr_en), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
